// File: rtl/vga_fb_pkg.sv
// Shared types and default geometry for the VGA framebuffer SRAM controller.
package vga_fb_pkg;

  localparam int H_ACTIVE_DEF = 800;
  localparam int V_ACTIVE_DEF = 600;
  localparam int PIX_W_DEF    = 8;
  localparam int SRAM_AW_DEF  = 18;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DISP,
    ST_WR_SETUP,
    ST_WR_PULSE
  } fb_state_t;

  typedef struct packed {
    logic [SRAM_AW_DEF-1:0] word_addr;
    logic                   lane;
    logic [PIX_W_DEF-1:0]   data;
  } fb_wr_entry_t;

endpackage

// File: rtl/fb_wr_fifo.sv
// Synchronous write queue of framebuffer entries with an occupancy count.
module fb_wr_fifo
  import vga_fb_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  fb_wr_entry_t             din,
  output fb_wr_entry_t             dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  fb_wr_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/vga_fb_sram_ctrl.sv
// Framebuffer controller: display reads from a 16-bit async SRAM during active video,
// queued pixel writes drained to the SRAM during blanking.
//
//   state       | meaning
//   ST_IDLE     | bus parked; pick display read or start a queued write
//   ST_DISP     | one display read issued per cycle while display_enable=1
//   ST_WR_SETUP | address/data/lane mask driven, we_n still high
//   ST_WR_PULSE | we_n low for one cycle, head entry popped on exit
module vga_fb_sram_ctrl
  import vga_fb_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int PIX_W      = PIX_W_DEF,
  parameter int SRAM_AW    = SRAM_AW_DEF,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          display_enable,
  input  logic [9:0]                    x_pos,
  input  logic [9:0]                    y_pos,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [9:0]                    wr_x,
  input  logic [9:0]                    wr_y,
  input  logic [PIX_W-1:0]              wr_data,
  output logic [PIX_W-1:0]              pix_out,
  output logic                          pix_valid,
  output logic [SRAM_AW-1:0]            sram_addr,
  inout  wire  [2*PIX_W-1:0]            sram_dq,
  output logic                          sram_we_n,
  output logic                          sram_oe_n,
  output logic                          sram_ub_n,
  output logic                          sram_lb_n,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          oob_err,
  output logic                          rd_miss
);

  localparam int P_W = SRAM_AW + 1;

  fb_state_t      state;
  fb_wr_entry_t   wr_entry;
  fb_wr_entry_t   wr_head;
  logic [P_W-1:0] rd_p;
  logic [P_W-1:0] wr_p;
  logic           wr_in_bounds;
  logic           fifo_push;
  logic           fifo_pop;
  logic           fifo_full;
  logic           fifo_empty;
  logic           dq_oe;
  logic [2*PIX_W-1:0] dq_out;
  logic           lane_q;
  logic           rd_req;
  logic           miss_q;

  assign rd_p = P_W'(y_pos) * P_W'(H_ACTIVE) + P_W'(x_pos);
  assign wr_p = P_W'(wr_y) * P_W'(H_ACTIVE) + P_W'(wr_x);

  assign wr_in_bounds = (int'(wr_x) < H_ACTIVE) && (int'(wr_y) < V_ACTIVE);
  assign wr_ready     = !fifo_full;
  assign fifo_push    = wr_valid && wr_ready && wr_in_bounds;
  assign fifo_pop     = (state == ST_WR_PULSE);

  assign wr_entry.word_addr = wr_p[SRAM_AW:1];
  assign wr_entry.lane      = wr_p[0];
  assign wr_entry.data      = wr_data;

  assign busy    = !fifo_empty || (state == ST_WR_SETUP) || (state == ST_WR_PULSE);
  assign sram_dq = dq_oe ? dq_out : 'z;

  fb_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_wr_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (wr_entry),
    .dout  (wr_head),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) oob_err <= 1'b0;
    else if (wr_valid && wr_ready && !wr_in_bounds) oob_err <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      sram_addr <= '0;
      sram_we_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_ub_n <= 1'b1;
      sram_lb_n <= 1'b1;
      dq_oe     <= 1'b0;
      dq_out    <= '0;
      lane_q    <= 1'b0;
      rd_req    <= 1'b0;
      miss_q    <= 1'b0;
      pix_out   <= '0;
      pix_valid <= 1'b0;
      rd_miss   <= 1'b0;
    end else begin
      // Data for the read issued last cycle is on the bus now.
      pix_valid <= rd_req && !miss_q;
      pix_out   <= (rd_req && !miss_q)
                   ? (lane_q ? sram_dq[2*PIX_W-1:PIX_W] : sram_dq[PIX_W-1:0]) : '0;
      if (miss_q) rd_miss <= 1'b1;
      rd_req <= 1'b0;
      miss_q <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (display_enable) begin
            state     <= ST_DISP;
            sram_addr <= rd_p[SRAM_AW:1];
            lane_q    <= rd_p[0];
            sram_oe_n <= 1'b0;
            sram_ub_n <= 1'b0;
            sram_lb_n <= 1'b0;
            rd_req    <= 1'b1;
          end else if (!fifo_empty) begin
            state     <= ST_WR_SETUP;
            sram_addr <= wr_head.word_addr;
            dq_out    <= {wr_head.data, wr_head.data};
            dq_oe     <= 1'b1;
            sram_ub_n <= !wr_head.lane;
            sram_lb_n <= wr_head.lane;
          end
        end
        ST_DISP: begin
          if (display_enable) begin
            sram_addr <= rd_p[SRAM_AW:1];
            lane_q    <= rd_p[0];
            rd_req    <= 1'b1;
          end else begin
            state     <= ST_IDLE;
            sram_oe_n <= 1'b1;
            sram_ub_n <= 1'b1;
            sram_lb_n <= 1'b1;
          end
        end
        ST_WR_SETUP: begin
          // Display wins: abandon the setup, entry stays queued for a later retry.
          if (display_enable) begin
            state     <= ST_DISP;
            dq_oe     <= 1'b0;
            sram_addr <= rd_p[SRAM_AW:1];
            lane_q    <= rd_p[0];
            sram_oe_n <= 1'b0;
            sram_ub_n <= 1'b0;
            sram_lb_n <= 1'b0;
            rd_req    <= 1'b1;
          end else begin
            state     <= ST_WR_PULSE;
            sram_we_n <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          sram_we_n <= 1'b1;
          dq_oe     <= 1'b0;
          sram_ub_n <= 1'b1;
          sram_lb_n <= 1'b1;
          if (display_enable) begin
            rd_req <= 1'b1;
            miss_q <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_fb_sram_ctrl.sv
// Bench for vga_fb_sram_ctrl: async SRAM model plus a pixel-level reference framebuffer.
module tb_vga_fb_sram_ctrl;
  import vga_fb_pkg::*;

  localparam int HA = 800;
  localparam int VA = 600;
  localparam int AW = 18;
  localparam int FD = 16;
  localparam int LW = $clog2(FD) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          display_enable = 1'b0;
  logic [9:0]    x_pos = '0, y_pos = '0, wr_x = '0, wr_y = '0;
  logic          wr_valid = 1'b0;
  logic [7:0]    wr_data = '0;
  wire  [15:0]   sram_dq;
  logic          wr_ready, pix_valid, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n;
  logic          busy, oob_err, rd_miss;
  logic [7:0]    pix_out;
  logic [AW-1:0] sram_addr;
  logic [LW-1:0] fifo_level;

  always #5 clk = ~clk;

  vga_fb_sram_ctrl #(.H_ACTIVE(HA), .V_ACTIVE(VA), .PIX_W(8), .SRAM_AW(AW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n), .display_enable(display_enable), .x_pos(x_pos), .y_pos(y_pos),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
    .pix_out(pix_out), .pix_valid(pix_valid), .sram_addr(sram_addr), .sram_dq(sram_dq),
    .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n),
    .busy(busy), .fifo_level(fifo_level), .oob_err(oob_err), .rd_miss(rd_miss)
  );

  // Async SRAM: combinational read, byte-masked write captured while we_n is low.
  logic [15:0] sram_mem [0:(1<<AW)-1];
  int          we_pulses = 0;
  assign sram_dq = (!sram_oe_n && sram_we_n) ? sram_mem[sram_addr] : 16'hzzzz;

  always @(posedge clk) begin
    if (rst_n && sram_we_n === 1'b0) begin
      we_pulses++;
      if (!sram_ub_n) sram_mem[sram_addr][15:8] = sram_dq[15:8];
      if (!sram_lb_n) sram_mem[sram_addr][7:0]  = sram_dq[7:0];
    end
  end

  // Reference framebuffer: a formula for untouched pixels, overridden by accepted writes.
  logic [7:0] ref_wr [int];

  function automatic logic [7:0] init_pix(int p);
    logic [31:0] v;
    v = p;
    return v[7:0] ^ v[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ref_pix(int p);
    if (ref_wr.exists(p)) return ref_wr[p];
    return init_pix(p);
  endfunction

  function automatic logic [7:0] sram_pix(int p);
    logic [15:0] w;
    w = sram_mem[AW'(p / 2)];
    return (p % 2 == 1) ? w[15:8] : w[7:0];
  endfunction

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_write(input int x, input int y, input logic [7:0] d);
    int n;
    n = 0;
    wr_x = 10'(x); wr_y = 10'(y); wr_data = d; wr_valid = 1'b1;
    while (!wr_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("wr_accept", 32'(wr_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    wr_valid = 1'b0;
    if (x < HA && y < VA) ref_wr[y*HA + x] = d;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300 && busy !== 1'b0; i++) @(negedge clk);
    check("drain", 32'(busy), 32'd0);
  endtask

  // Display pipeline expectation: pixel presented at one negedge shows two negedges later.
  logic st1_v = 1'b0, st2_v = 1'b0;
  int   st1_p = 0, st2_p = 0;

  task automatic disp_step(input logic de, input int x, input int y);
    check("pix_valid", 32'(pix_valid), 32'(st2_v));
    if (st2_v) check("pix_out", 32'(pix_out), 32'(ref_pix(st2_p)));
    st2_v = st1_v; st2_p = st1_p;
    st1_v = de;    st1_p = y*HA + x;
    display_enable = de; x_pos = 10'(x); y_pos = 10'(y);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int p0, p, x, y;
    int list4 [$];
    int wr_list [$];
    logic [7:0] d;

    for (int w = 0; w < (1<<AW); w++) sram_mem[w] = {init_pix(2*w+1), init_pix(2*w)};

    // 1. reset state
    repeat (3) @(negedge clk);
    check("rst_we_n", 32'(sram_we_n), 32'd1);
    check("rst_oe_n", 32'(sram_oe_n), 32'd1);
    check("rst_ub_n", 32'(sram_ub_n), 32'd1);
    check("rst_lb_n", 32'(sram_lb_n), 32'd1);
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_pix_valid", 32'(pix_valid), 32'd0);
    check("rst_pix_out", 32'(pix_out), 32'd0);
    check("rst_flags", {30'd0, oob_err, rd_miss}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_wr_ready", 32'(wr_ready), 32'd1);

    // 2. single write during blanking, odd pixel -> high lane
    p0 = we_pulses;
    do_write(3, 0, 8'hA5);
    check("t2_busy", 32'(busy), 32'd1);
    check("t2_level", 32'(fifo_level), 32'd1);
    check("t2_we_idle", 32'(sram_we_n), 32'd1);
    @(negedge clk);
    check("t2_addr", 32'(sram_addr), 32'd1);
    check("t2_ub_n", 32'(sram_ub_n), 32'd0);
    check("t2_lb_n", 32'(sram_lb_n), 32'd1);
    check("t2_setup_we", 32'(sram_we_n), 32'd1);
    check("t2_setup_oe", 32'(sram_oe_n), 32'd1);
    check("t2_dq_hi", 32'(sram_dq[15:8]), 32'hA5);
    @(negedge clk);
    check("t2_pulse_we", 32'(sram_we_n), 32'd0);
    check("t2_pulse_addr", 32'(sram_addr), 32'd1);
    @(negedge clk);
    check("t2_after_we", 32'(sram_we_n), 32'd1);
    check("t2_pulses", 32'(we_pulses - p0), 32'd1);
    check("t2_level_done", 32'(fifo_level), 32'd0);
    check("t2_mem_odd", 32'(sram_pix(3)), 32'(ref_pix(3)));
    check("t2_mem_even", 32'(sram_pix(2)), 32'(ref_pix(2)));

    // 3. display reads x=0..3, y=1 (words 400/401)
    for (int i = 0; i < 4; i++) disp_step(1'b1, i, 1);
    disp_step(1'b0, 0, 0);
    disp_step(1'b0, 0, 0);

    // 4. fill the queue while display holds the bus
    display_enable = 1'b1; x_pos = '0; y_pos = '0;
    p0 = we_pulses;
    @(negedge clk);
    for (int i = 0; i < FD; i++) begin
      x = $urandom_range(HA-1); y = $urandom_range(VA-1);
      list4.push_back(y*HA + x);
      do_write(x, y, 8'($urandom));
    end
    check("t4_full_level", 32'(fifo_level), 32'(FD));
    check("t4_full_ready", 32'(wr_ready), 32'd0);
    x = $urandom_range(HA-1); y = $urandom_range(VA-1); d = 8'($urandom);
    wr_x = 10'(x); wr_y = 10'(y); wr_data = d; wr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_stall_level", 32'(fifo_level), 32'(FD));
    end
    check("t4_no_pulse_in_disp", 32'(we_pulses - p0), 32'd0);
    display_enable = 1'b0;
    for (int i = 0; i < 50 && !wr_ready; i++) @(negedge clk);
    check("t4_ready_after_pop", 32'(wr_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    wr_valid = 1'b0;
    ref_wr[y*HA + x] = d;
    list4.push_back(y*HA + x);
    check("t4_refill_level", 32'(fifo_level), 32'(FD));
    wait_idle();
    check("t4_pulses", 32'(we_pulses - p0), 32'(FD + 1));
    foreach (list4[i]) check("t4_mem", 32'(sram_pix(list4[i])), 32'(ref_pix(list4[i])));
    st1_v = 1'b0; st2_v = 1'b0;

    // 5a. display rises during WR_SETUP: no pulse, entry retried
    p0 = we_pulses;
    do_write(10, 2, 8'h3C);
    @(negedge clk);
    check("t5a_setup_addr", 32'(sram_addr), 32'd805);
    check("t5a_setup_we", 32'(sram_we_n), 32'd1);
    display_enable = 1'b1; x_pos = 10'd10; y_pos = 10'd2;
    @(negedge clk);
    check("t5a_retry_level", 32'(fifo_level), 32'd1);
    check("t5a_read_oe", 32'(sram_oe_n), 32'd0);
    repeat (3) @(negedge clk);
    check("t5a_no_pulse", 32'(we_pulses - p0), 32'd0);
    display_enable = 1'b0;
    wait_idle();
    check("t5a_pulse", 32'(we_pulses - p0), 32'd1);
    check("t5a_mem", 32'(sram_pix(2*HA + 10)), 32'(ref_pix(2*HA + 10)));

    // 5b. display rises during WR_PULSE: pulse completes, one missed pixel
    check("t5b_miss_clear", 32'(rd_miss), 32'd0);
    p0 = we_pulses;
    do_write(21, 3, 8'hC3);
    @(negedge clk);
    @(negedge clk);
    check("t5b_pulse_we", 32'(sram_we_n), 32'd0);
    display_enable = 1'b1; x_pos = 10'd21; y_pos = 10'd3;
    @(negedge clk);
    check("t5b_we_release", 32'(sram_we_n), 32'd1);
    check("t5b_level", 32'(fifo_level), 32'd0);
    @(negedge clk);
    check("t5b_miss_valid", 32'(pix_valid), 32'd0);
    check("t5b_miss_out", 32'(pix_out), 32'd0);
    check("t5b_miss_flag", 32'(rd_miss), 32'd1);
    @(negedge clk);
    check("t5b_next_valid", 32'(pix_valid), 32'd1);
    check("t5b_next_pix", 32'(pix_out), 32'(ref_pix(3*HA + 21)));
    display_enable = 1'b0;
    repeat (3) @(negedge clk);
    check("t5b_sticky", 32'(rd_miss), 32'd1);
    check("t5b_pulses", 32'(we_pulses - p0), 32'd1);

    // 6. out-of-bounds writes: handshaken, dropped, flagged
    check("t6_oob_clear", 32'(oob_err), 32'd0);
    p0 = we_pulses;
    do_write(800, 0, 8'h77);
    check("t6_oob_flag", 32'(oob_err), 32'd1);
    check("t6_level", 32'(fifo_level), 32'd0);
    do_write(5, 600, 8'h66);
    repeat (4) @(negedge clk);
    check("t6_no_pulse", 32'(we_pulses - p0), 32'd0);
    check("t6_mem_800", 32'(sram_pix(800)), 32'(ref_pix(800)));

    // randomized writes then randomized display reads
    for (int i = 0; i < 40; i++) begin
      x = $urandom_range(HA-1); y = $urandom_range(VA-1);
      if ($urandom_range(9) == 0) x = HA + $urandom_range(200);
      else if ($urandom_range(9) == 0) y = VA + $urandom_range(400);
      else wr_list.push_back(y*HA + x);
      do_write(x, y, 8'($urandom));
    end
    wait_idle();
    st1_v = 1'b0; st2_v = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(1) == 1) p = wr_list[$urandom_range(wr_list.size()-1)];
      else p = $urandom_range(HA*VA-1);
      disp_step($urandom_range(9) < 8, p % HA, p / HA);
    end
    disp_step(1'b0, 0, 0);
    disp_step(1'b0, 0, 0);
    check("final_oob", 32'(oob_err), 32'd1);
    check("final_miss", 32'(rd_miss), 32'd1);

    // reset asserted mid-pulse
    p0 = we_pulses;
    do_write(7, 7, 8'h11);
    @(negedge clk);
    @(negedge clk);
    check("mid_rst_pulse", 32'(sram_we_n), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_we", 32'(sram_we_n), 32'd1);
    check("mid_rst_level", 32'(fifo_level), 32'd0);
    @(negedge clk);
    check("mid_rst_no_write", 32'(we_pulses - p0), 32'd0);
    check("mid_rst_flags", {30'd0, oob_err, rd_miss}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_rst_busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
